// File: rtl/mxu_pkg.sv
// rtl/mxu_pkg.sv - shared FSM state encoding and default sizes for the matrix unit
package mxu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } mxu_state_e;

  localparam int MXU_DIM_DEFAULT   = 4;
  localparam int MXU_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/mxu_mac.sv
// rtl/mxu_mac.sv - one output element: WIDTH x WIDTH multiply into a wrapping accumulator
module mxu_mac #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 22,
  parameter int SIGNED    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [OUT_WIDTH-1:0] y
);

  logic [OUT_WIDTH-1:0] prod_ext;

  // Operands are widened to the full product width first so the multiply is exact.
  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [2*WIDTH-1:0] prod;
      assign prod     = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
      assign prod_ext = OUT_WIDTH'(prod);
    end else begin : g_unsigned
      logic [2*WIDTH-1:0] prod;
      assign prod     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      assign prod_ext = OUT_WIDTH'(prod);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      y <= '0;
    end else if (en) begin
      y <= y + prod_ext;
    end
  end

endmodule

// File: rtl/mxu_stream.sv
// rtl/mxu_stream.sv - DIM x DIM matrix multiply-accumulate, one outer product per cycle
module mxu_stream
  import mxu_pkg::*;
#(
  parameter int DIM       = MXU_DIM_DEFAULT,
  parameter int WIDTH     = MXU_WIDTH_DEFAULT,
  parameter int OUT_WIDTH = 2*WIDTH + $clog2(DIM) + 4,
  parameter int SIGNED    = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DIM*DIM*WIDTH-1:0]       in0,
  input  logic [DIM*DIM*WIDTH-1:0]       in1,
  input  logic                           acc_en,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [DIM*DIM*OUT_WIDTH-1:0]   out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy
);

  localparam int KW = $clog2(DIM);

  mxu_state_e               state_q, state_d;
  logic [KW-1:0]            k_q;
  logic [DIM*DIM*WIDTH-1:0] a_q, b_q;
  logic                     accept;
  logic                     last_k;
  logic                     mac_clear;
  logic                     mac_en;
  logic [WIDTH-1:0]         a_col [DIM];
  logic [WIDTH-1:0]         b_row [DIM];

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready & ~reset;
  assign last_k    = (k_q == KW'(DIM - 1));
  assign busy      = (state_q == ST_COMPUTE);
  assign out_valid = (state_q == ST_DONE);
  assign mac_clear = accept & ~acc_en;
  assign mac_en    = (state_q == ST_COMPUTE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_COMPUTE;
      ST_COMPUTE: if (last_k) state_d = ST_DONE;
      ST_DONE: begin
        if (accept) begin
          state_d = ST_COMPUTE;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q <= '0;
    end else if (accept) begin
      k_q <= '0;
    end else if (state_q == ST_COMPUTE) begin
      k_q <= k_q + KW'(1);
    end
  end

  // Operands are pure datapath; an abort only needs the FSM and accumulators cleared.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= in0;
      b_q <= in1;
    end
  end

  genvar i, j;
  generate
    for (i = 0; i < DIM; i++) begin : g_sel
      assign a_col[i] = a_q[(i*DIM + int'(k_q))*WIDTH +: WIDTH];
      assign b_row[i] = b_q[(int'(k_q)*DIM + i)*WIDTH +: WIDTH];
    end

    for (i = 0; i < DIM; i++) begin : g_row
      for (j = 0; j < DIM; j++) begin : g_col
        mxu_mac #(
          .WIDTH     (WIDTH),
          .OUT_WIDTH (OUT_WIDTH),
          .SIGNED    (SIGNED)
        ) u_mac (
          .clk   (clk),
          .reset (reset),
          .clear (mac_clear),
          .en    (mac_en),
          .a     (a_col[i]),
          .b     (b_row[j]),
          .y     (out[(i*DIM + j)*OUT_WIDTH +: OUT_WIDTH])
        );
      end
    end
  endgenerate

endmodule

// File: tb/tb_mxu_stream.sv
// tb/tb_mxu_stream.sv - directed and reference-model checks of mxu_stream, unsigned and signed builds
module tb_mxu_stream;

  localparam int DIM = 4;
  localparam int W   = 8;
  localparam int OW  = 2*W + $clog2(DIM) + 4;
  localparam int NE  = DIM*DIM;

  typedef logic [NE*W-1:0]  mat_t;
  typedef logic [NE*OW-1:0] res_t;

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  mat_t in0       = '0;
  mat_t in1       = '0;
  logic acc_en    = 1'b0;
  logic in_valid  = 1'b0;
  logic out_ready = 1'b0;

  res_t out_u, out_s;
  logic in_ready_u, in_ready_s, out_valid_u, out_valid_s, busy_u, busy_s;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mxu_stream #(.DIM(DIM), .WIDTH(W), .OUT_WIDTH(OW), .SIGNED(0)) dut_u (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1), .acc_en(acc_en),
    .in_valid(in_valid), .in_ready(in_ready_u), .out(out_u),
    .out_valid(out_valid_u), .out_ready(out_ready), .busy(busy_u)
  );

  mxu_stream #(.DIM(DIM), .WIDTH(W), .OUT_WIDTH(OW), .SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1), .acc_en(acc_en),
    .in_valid(in_valid), .in_ready(in_ready_s), .out(out_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .busy(busy_s)
  );

  function automatic res_t model(mat_t a, mat_t b, res_t prev, logic acc, bit sgn);
    res_t          y;
    logic [OW-1:0] s;
    logic [W-1:0]  ea, eb;
    int            x, z;
    y = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        s = acc ? prev[(r*DIM+c)*OW +: OW] : '0;
        for (int k = 0; k < DIM; k++) begin
          ea = a[(r*DIM+k)*W +: W];
          eb = b[(k*DIM+c)*W +: W];
          x  = sgn ? int'($signed(ea)) : int'(ea);
          z  = sgn ? int'($signed(eb)) : int'(eb);
          s  = s + OW'(x*z);
        end
        y[(r*DIM+c)*OW +: OW] = s;
      end
    end
    return y;
  endfunction

  function automatic mat_t identity();
    mat_t m = '0;
    for (int r = 0; r < DIM; r++) m[(r*DIM+r)*W +: W] = W'(1);
    return m;
  endfunction

  function automatic mat_t ramp();
    mat_t m;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) m[(r*DIM+c)*W +: W] = W'(4*r + c);
    return m;
  endfunction

  function automatic res_t ramp_res(int mult);
    res_t y;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) y[(r*DIM+c)*OW +: OW] = OW'(mult*(4*r + c));
    return y;
  endfunction

  function automatic mat_t fill_mat(logic [W-1:0] v);
    mat_t m;
    for (int e = 0; e < NE; e++) m[e*W +: W] = v;
    return m;
  endfunction

  function automatic res_t fill_res(logic [OW-1:0] v);
    res_t y;
    for (int e = 0; e < NE; e++) y[e*OW +: OW] = v;
    return y;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int e = 0; e < NE; e++) m[e*W +: W] = W'($urandom_range(0, 255));
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input mat_t a, input mat_t b, input logic acc);
    int n;
    in0 = a; in1 = b; acc_en = acc; in_valid = 1'b1;
    n = 0;
    while (!in_ready_u && n < 50) begin
      step();
      n++;
    end
    total_cnt++;
    if (in_ready_u !== 1'b1) $display("FAIL issue_ready: in_ready=%b required 1 within 50 cycles", in_ready_u);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid_u && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    total_cnt++; if (out_valid_u !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid_u); else pass_cnt++;
    total_cnt++; if (busy_u !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_u); else pass_cnt++;
    total_cnt++; if (out_u !== '0) $display("FAIL rst_out: got %h want 0", out_u); else pass_cnt++;
    total_cnt++; if (out_s !== '0) $display("FAIL rst_out_s: got %h want 0", out_s); else pass_cnt++;
    total_cnt++; if (in_ready_u !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready_u); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_identity();
    int lat;
    out_ready = 1'b0;
    issue(identity(), ramp(), 1'b0);
    total_cnt++; if (busy_u !== 1'b1) $display("FAIL id_busy: got %b want 1", busy_u); else pass_cnt++;
    wait_valid(lat);
    total_cnt++; if (lat !== DIM) $display("FAIL id_latency: got %0d want %0d", lat, DIM); else pass_cnt++;
    total_cnt++; if (out_u !== ramp_res(1)) $display("FAIL id_out: got %h want %h", out_u, ramp_res(1)); else pass_cnt++;
    total_cnt++; if (out_s !== ramp_res(1)) $display("FAIL id_out_s: got %h want %h", out_s, ramp_res(1)); else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++; if (out_valid_u !== 1'b0) $display("FAIL id_release: out_valid=%b want 0", out_valid_u); else pass_cnt++;
    total_cnt++; if (in_ready_u !== 1'b1) $display("FAIL id_idle_ready: got %b want 1", in_ready_u); else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    in0 = identity(); in1 = ramp(); acc_en = 1'b0; in_valid = 1'b1;
    step();
    acc_en = 1'b1;
    wait_valid(lat);
    total_cnt++; if (lat !== DIM) $display("FAIL b2b_lat1: got %0d want %0d", lat, DIM); else pass_cnt++;
    total_cnt++; if (out_u !== ramp_res(1)) $display("FAIL b2b_out1: got %h want %h", out_u, ramp_res(1)); else pass_cnt++;
    total_cnt++; if (in_ready_u !== 1'b1) $display("FAIL b2b_ready: got %b want 1", in_ready_u); else pass_cnt++;
    step();
    total_cnt++; if (busy_u !== 1'b1) $display("FAIL b2b_no_idle: busy=%b want 1", busy_u); else pass_cnt++;
    total_cnt++; if (out_valid_u !== 1'b0) $display("FAIL b2b_valid_drop: got %b want 0", out_valid_u); else pass_cnt++;
    in_valid = 1'b0;
    wait_valid(lat);
    total_cnt++; if (lat !== DIM) $display("FAIL b2b_lat2: got %0d want %0d", lat, DIM); else pass_cnt++;
    total_cnt++; if (out_u !== ramp_res(2)) $display("FAIL b2b_out2: got %h want %h", out_u, ramp_res(2)); else pass_cnt++;
    total_cnt++; if (out_s !== ramp_res(2)) $display("FAIL b2b_out2_s: got %h want %h", out_s, ramp_res(2)); else pass_cnt++;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    int lat;
    out_ready = 1'b0;
    issue(identity(), ramp(), 1'b0);
    wait_valid(lat);
    total_cnt++; if (lat !== DIM) $display("FAIL stall_lat: got %0d want %0d", lat, DIM); else pass_cnt++;
    in0 = fill_mat(8'h11); in1 = fill_mat(8'h22); acc_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      step();
      total_cnt++; if (out_valid_u !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid_u); else pass_cnt++;
      total_cnt++; if (out_u !== ramp_res(1)) $display("FAIL stall_out[%0d]: got %h want %h", i, out_u, ramp_res(1)); else pass_cnt++;
      total_cnt++; if (in_ready_u !== 1'b0) $display("FAIL stall_ready[%0d]: got %b want 0", i, in_ready_u); else pass_cnt++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    total_cnt++; if (out_valid_u !== 1'b0) $display("FAIL stall_release: got %b want 0", out_valid_u); else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_signed();
    int lat;
    out_ready = 1'b0;
    issue(fill_mat(8'h80), fill_mat(8'h80), 1'b0);
    wait_valid(lat);
    total_cnt++; if (out_s !== fill_res(OW'(65536))) $display("FAIL sgn_min_s: got %h want %h", out_s, fill_res(OW'(65536))); else pass_cnt++;
    total_cnt++; if (out_u !== fill_res(OW'(65536))) $display("FAIL sgn_min_u: got %h want %h", out_u, fill_res(OW'(65536))); else pass_cnt++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    issue(fill_mat(8'hFF), fill_mat(8'h02), 1'b0);
    wait_valid(lat);
    total_cnt++; if (out_s !== fill_res(22'h3FFFF8)) $display("FAIL sgn_neg_s: got %h want %h", out_s, fill_res(22'h3FFFF8)); else pass_cnt++;
    total_cnt++; if (out_u !== fill_res(OW'(2040))) $display("FAIL sgn_neg_u: got %h want %h", out_u, fill_res(OW'(2040))); else pass_cnt++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    int   lat;
    res_t exp;
    out_ready = 1'b0;
    issue(identity(), ramp(), 1'b0);
    step(); step();
    reset = 1'b1;
    step();
    total_cnt++; if (busy_u !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy_u); else pass_cnt++;
    total_cnt++; if (out_valid_u !== 1'b0) $display("FAIL abort_valid: got %b want 0", out_valid_u); else pass_cnt++;
    total_cnt++; if (out_u !== '0) $display("FAIL abort_out: got %h want 0", out_u); else pass_cnt++;
    total_cnt++; if (in_ready_u !== 1'b1) $display("FAIL abort_ready: got %b want 1", in_ready_u); else pass_cnt++;
    reset = 1'b0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) exp[(r*DIM+c)*OW +: OW] = OW'(72 + 12*c);
    issue(fill_mat(8'h03), ramp(), 1'b1);
    wait_valid(lat);
    total_cnt++; if (lat !== DIM) $display("FAIL abort_lat: got %0d want %0d", lat, DIM); else pass_cnt++;
    total_cnt++; if (out_u !== exp) $display("FAIL abort_fresh: got %h want %h", out_u, exp); else pass_cnt++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int   lat, n;
    mat_t a, b;
    logic acc;
    res_t prev_u, prev_s, exp_u, exp_s;
    prev_u = '0; prev_s = '0;
    out_ready = 1'b1;
    for (int it = 0; it < 100; it++) begin
      a = rand_mat(); b = rand_mat();
      acc = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      in0 = a; in1 = b; acc_en = acc; in_valid = 1'b1;
      n = 0;
      while (!in_ready_u && n < 20) begin
        step();
        n++;
      end
      total_cnt++; if (in_ready_u !== 1'b1 || n != 0) $display("FAIL rnd_ready[%0d]: ready=%b wait=%0d want 1 and 0", it, in_ready_u, n); else pass_cnt++;
      step();
      exp_u = model(a, b, prev_u, acc, 1'b0);
      exp_s = model(a, b, prev_s, acc, 1'b1);
      wait_valid(lat);
      total_cnt++; if (lat !== DIM) $display("FAIL rnd_lat[%0d]: got %0d want %0d", it, lat, DIM); else pass_cnt++;
      total_cnt++; if (out_u !== exp_u) $display("FAIL rnd_u[%0d]: got %h want %h", it, out_u, exp_u); else pass_cnt++;
      total_cnt++; if (out_s !== exp_s) $display("FAIL rnd_s[%0d]: got %h want %h", it, out_s, exp_s); else pass_cnt++;
      prev_u = exp_u;
      prev_s = exp_s;
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_identity();
    test_back_to_back();
    test_stall();
    test_signed();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
